// File: rtl/instr_decode_pkg.sv
// Shared definitions for the MIPS decode stage: opcode/funct values,
// control-field encodings and the packed control bundle that the
// combinational decoder hands to the pipeline register.
package instr_decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_XOR = 3'd2,
        ALU_SLT = 3'd3, ALU_AND = 3'd4, ALU_OR  = 3'd5
    } alu_ctrl_e;

    typedef enum logic [1:0] {BR_NONE  = 2'd0, BR_BNE = 2'd1, BR_BEQ  = 2'd2} branch_e;
    typedef enum logic [1:0] {JMP_NONE = 2'd0, JMP_JR = 2'd1, JMP_J   = 2'd2} jump_e;
    typedef enum logic [1:0] {DST_RT   = 2'd0, DST_RD = 2'd1, DST_R31 = 2'd2} reg_dst_e;
    typedef enum logic [1:0] {WB_ALU   = 2'd0, WB_MEM = 2'd1, WB_LINK = 2'd2} wb_sel_e;

    typedef struct packed {
        branch_e   branch;
        jump_e     jump;
        reg_dst_e  reg_dst;
        wb_sel_e   mem_to_reg;
        logic      reg_write;
        logic      mem_read;
        logic      mem_write;
        logic      alu_src;
        alu_ctrl_e alu_ctrl;
        logic      illegal;
    } ctrl_t;

endpackage

// File: rtl/instr_decode_comb.sv
// Pure combinational decoder: instruction word -> control bundle,
// extended immediate, and which source registers the instruction reads.
// Ports:
//   i_instr    raw 32-bit instruction
//   o_ctrl     control bundle (illegal flag included)
//   o_imm_ext  immediate extended to DATA_W
//   o_uses_rs  instruction reads rs (everything but J/JAL)
//   o_uses_rt  instruction reads rt (R-type, SW, BEQ, BNE)
module instr_decode_comb
    import instr_decode_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       i_instr,
    output ctrl_t             o_ctrl,
    output logic [DATA_W-1:0] o_imm_ext,
    output logic              o_uses_rs,
    output logic              o_uses_rt
);

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;

    assign w_op    = i_instr[31:26];
    assign w_funct = i_instr[5:0];
    assign w_imm   = i_instr[15:0];

    always_comb begin
        o_ctrl    = '0;
        o_imm_ext = DATA_W'($signed(w_imm));
        o_uses_rs = 1'b1;
        o_uses_rt = 1'b0;
        case (w_op)
            OP_LW: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_to_reg = WB_MEM;
            end
            OP_SW: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_uses_rt        = 1'b1;
            end
            OP_J: begin
                o_ctrl.jump = JMP_J;
                o_uses_rs   = 1'b0;
            end
            OP_JAL: begin
                o_ctrl.jump       = JMP_J;
                o_ctrl.reg_dst    = DST_R31;
                o_ctrl.mem_to_reg = WB_LINK;
                o_ctrl.reg_write  = 1'b1;
                o_imm_ext         = DATA_W'(32'd8);  // link offset PC+8
                o_uses_rs         = 1'b0;
            end
            OP_BEQ: begin
                o_ctrl.branch   = BR_BEQ;
                o_ctrl.alu_ctrl = ALU_SUB;
                o_uses_rt       = 1'b1;
            end
            OP_BNE: begin
                o_ctrl.branch   = BR_BNE;
                o_ctrl.alu_ctrl = ALU_SUB;
                o_uses_rt       = 1'b1;
            end
            OP_ADDI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
            end
            OP_XORI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_ctrl  = ALU_XOR;
                o_imm_ext        = DATA_W'(w_imm);   // logical op: zero-extend
            end
            OP_RTYPE: begin
                o_uses_rt = 1'b1;
                case (w_funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
                        o_ctrl.reg_write = 1'b1;
                        o_ctrl.reg_dst   = DST_RD;
                        case (w_funct)
                            FN_SUB:  o_ctrl.alu_ctrl = ALU_SUB;
                            FN_AND:  o_ctrl.alu_ctrl = ALU_AND;
                            FN_OR:   o_ctrl.alu_ctrl = ALU_OR;
                            FN_SLT:  o_ctrl.alu_ctrl = ALU_SLT;
                            default: o_ctrl.alu_ctrl = ALU_ADD;
                        endcase
                    end
                    FN_JR:   o_ctrl.jump    = JMP_JR;
                    default: o_ctrl.illegal = 1'b1;
                endcase
            end
            default: o_ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage between fetch and register-read. One instruction
// per valid/ready handshake, decoded bundle presented one cycle later.
// flush kills the stage (and any same-cycle transfer).
// Optional build macro LOAD_USE_STALL_EN: inserts one bubble when the
// incoming instruction reads the rt of an LW sitting in the stage, and
// exposes a saturating bubble counter on stall_cnt.
// Ports: clk/rst_n (async active-low); in_valid/in_ready/instruction/pc_in
// from fetch; out_valid/out_ready plus decoded fields (branch, jump, reg_dst,
// mem_to_reg, reg_write, mem_read, mem_write, alu_src, alu_ctrl, rs, rt, rd,
// imm_ext, target, pc_out, illegal) to execute; flush from branch resolution.
module instr_decode_stage
    import instr_decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        branch,
    output logic [1:0]        jump,
    output logic [1:0]        reg_dst,
    output logic [1:0]        mem_to_reg,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              alu_src,
    output logic [2:0]        alu_ctrl,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [DATA_W-1:0] imm_ext,
    output logic [25:0]       target,
    output logic [PC_W-1:0]   pc_out,
`ifdef LOAD_USE_STALL_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              illegal
);

    ctrl_t             w_ctrl;
    logic [DATA_W-1:0] w_imm_ext;
    logic              w_uses_rs;
    logic              w_uses_rt;
    logic              w_slot_free;
    logic              w_xfer;

    ctrl_t             r_ctrl;
    logic              r_vld;
    logic [4:0]        r_rs, r_rt, r_rd;
    logic [DATA_W-1:0] r_imm_ext;
    logic [25:0]       r_target;
    logic [PC_W-1:0]   r_pc;

    instr_decode_comb #(.DATA_W(DATA_W)) u_dec (
        .i_instr   (instruction),
        .o_ctrl    (w_ctrl),
        .o_imm_ext (w_imm_ext),
        .o_uses_rs (w_uses_rs),
        .o_uses_rt (w_uses_rt)
    );

    assign w_slot_free = !r_vld || out_ready;
    assign w_xfer      = in_valid && in_ready;

`ifdef LOAD_USE_STALL_EN
    logic       w_hazard;
    logic       r_ld_vld;
    logic [4:0] r_ld_rt;
    logic [15:0] r_stall_cnt;

    assign w_hazard = in_valid && r_ld_vld &&
                      ((w_uses_rs && instruction[25:21] == r_ld_rt) ||
                       (w_uses_rt && instruction[20:16] == r_ld_rt));
    assign in_ready  = w_slot_free && !w_hazard;
    assign stall_cnt = r_stall_cnt;

    // Tracks whether the bundle now in the stage is an LW writing a live reg.
    // Any cycle the slot drains without a new transfer, the load has moved on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_vld    <= 1'b0;
            r_ld_rt     <= '0;
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_ld_vld <= 1'b0;
        end else if (w_xfer) begin
            r_ld_vld <= w_ctrl.mem_read && (instruction[20:16] != 5'd0);
            r_ld_rt  <= instruction[20:16];
        end else if (w_slot_free) begin
            r_ld_vld <= 1'b0;
            if (w_hazard && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
`else
    logic w_unused_hzd;
    assign w_unused_hzd = w_uses_rs ^ w_uses_rt;
    assign in_ready     = w_slot_free;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld     <= 1'b0;
            r_ctrl    <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_imm_ext <= '0;
            r_target  <= '0;
            r_pc      <= '0;
        end else if (flush) begin
            r_vld <= 1'b0;
        end else if (w_xfer) begin
            r_vld     <= 1'b1;
            r_ctrl    <= w_ctrl;
            r_rs      <= instruction[25:21];
            r_rt      <= instruction[20:16];
            r_rd      <= instruction[15:11];
            r_imm_ext <= w_imm_ext;
            r_target  <= instruction[25:0];
            r_pc      <= pc_in;
        end else if (out_ready) begin
            r_vld <= 1'b0;
        end
    end

    assign out_valid  = r_vld;
    assign branch     = r_ctrl.branch;
    assign jump       = r_ctrl.jump;
    assign reg_dst    = r_ctrl.reg_dst;
    assign mem_to_reg = r_ctrl.mem_to_reg;
    assign reg_write  = r_ctrl.reg_write;
    assign mem_read   = r_ctrl.mem_read;
    assign mem_write  = r_ctrl.mem_write;
    assign alu_src    = r_ctrl.alu_src;
    assign alu_ctrl   = r_ctrl.alu_ctrl;
    assign illegal    = r_ctrl.illegal;
    assign rs         = r_rs;
    assign rt         = r_rt;
    assign rd         = r_rd;
    assign imm_ext    = r_imm_ext;
    assign target     = r_target;
    assign pc_out     = r_pc;

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [31:0] instruction = '0, pc_in = '0;
    logic        in_ready, out_valid;
    logic [1:0]  branch, jump, reg_dst, mem_to_reg;
    logic        reg_write, mem_read, mem_write, alu_src, illegal;
    logic [2:0]  alu_ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_ext, pc_out;
    logic [25:0] target;
`ifdef LOAD_USE_STALL_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    instr_decode_stage #(.DATA_W(32), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc_in(pc_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .branch(branch), .jump(jump), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src(alu_src), .alu_ctrl(alu_ctrl), .rs(rs), .rt(rt), .rd(rd),
        .imm_ext(imm_ext), .target(target), .pc_out(pc_out),
`ifdef LOAD_USE_STALL_EN
        .stall_cnt(stall_cnt),
`endif
        .illegal(illegal)
    );

    typedef struct packed {
        logic        vld;
        logic [1:0]  br, jmp, dst, wb;
        logic        rw, mr, mw, as;
        logic [2:0]  alu;
        logic [4:0]  rs, rt, rd;
        logic [31:0] imm;
        logic [25:0] tgt;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    exp_t        m;
    logic        m_ldv;
    logic [4:0]  m_ldrt;
    int          m_stall;
    int          n_vec = 0, n_err = 0;

    function automatic string mnem(input logic [31:0] i);
        case (i[31:26])
            6'h23: return "LW";
            6'h2B: return "SW";
            6'h02: return "J";
            6'h03: return "JAL";
            6'h04: return "BEQ";
            6'h05: return "BNE";
            6'h08: return "ADDI";
            6'h0E: return "XORI";
            6'h00: case (i[5:0])
                       6'h20: return "ADD";
                       6'h22: return "SUB";
                       6'h24: return "AND";
                       6'h25: return "OR";
                       6'h2A: return "SLT";
                       6'h08: return "JR";
                       default: return "ILL";
                   endcase
            default: return "ILL";
        endcase
    endfunction

    // Expected bundle straight from the instruction semantics.
    function automatic exp_t decode(input logic [31:0] i, input logic [31:0] pc);
        exp_t  e;
        string k;
        k = mnem(i);
        e = '0;
        e.vld = 1'b1;
        e.rs = i[25:21]; e.rt = i[20:16]; e.rd = i[15:11]; e.tgt = i[25:0];
        e.imm = {{16{i[15]}}, i[15:0]};
        e.pc = pc;
        if (k == "LW")        begin e.rw = 1; e.mr = 1; e.as = 1; e.wb = 2'd1; end
        else if (k == "SW")   begin e.mw = 1; e.as = 1; end
        else if (k == "J")    e.jmp = 2'd2;
        else if (k == "JAL")  begin e.jmp = 2'd2; e.dst = 2'd2; e.wb = 2'd2; e.rw = 1; e.imm = 32'd8; end
        else if (k == "BEQ")  begin e.br = 2'd2; e.alu = 3'd1; end
        else if (k == "BNE")  begin e.br = 2'd1; e.alu = 3'd1; end
        else if (k == "ADDI") begin e.rw = 1; e.as = 1; end
        else if (k == "XORI") begin e.rw = 1; e.as = 1; e.alu = 3'd2; e.imm = {16'h0, i[15:0]}; end
        else if (k == "JR")   e.jmp = 2'd1;
        else if (k == "ADD" || k == "SUB" || k == "AND" || k == "OR" || k == "SLT") begin
            e.rw = 1; e.dst = 2'd1;
            e.alu = (k == "SUB") ? 3'd1 : (k == "SLT") ? 3'd3 :
                    (k == "AND") ? 3'd4 : (k == "OR")  ? 3'd5 : 3'd0;
        end
        else e.ill = 1'b1;
        return e;
    endfunction

    function automatic logic reads_rs(input logic [31:0] i);
        return !(mnem(i) == "J" || mnem(i) == "JAL");
    endfunction

    function automatic logic reads_rt(input logic [31:0] i);
        return i[31:26] == 6'h00 || i[31:26] == 6'h2B || i[31:26] == 6'h04 || i[31:26] == 6'h05;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("out_valid",  64'(out_valid),  64'(m.vld));
        chk("branch",     64'(branch),     64'(m.br));
        chk("jump",       64'(jump),       64'(m.jmp));
        chk("reg_dst",    64'(reg_dst),    64'(m.dst));
        chk("mem_to_reg", 64'(mem_to_reg), 64'(m.wb));
        chk("ctl_bits",   64'({reg_write, mem_read, mem_write, alu_src}), 64'({m.rw, m.mr, m.mw, m.as}));
        chk("alu_ctrl",   64'(alu_ctrl),   64'(m.alu));
        chk("regs",       64'({rs, rt, rd}), 64'({m.rs, m.rt, m.rd}));
        chk("imm_ext",    64'(imm_ext),    64'(m.imm));
        chk("target",     64'(target),     64'(m.tgt));
        chk("pc_out",     64'(pc_out),     64'(m.pc));
        chk("illegal",    64'(illegal),    64'(m.ill));
`ifdef LOAD_USE_STALL_EN
        chk("stall_cnt",  64'(stall_cnt),  64'(m_stall));
`endif
    endtask

    // One clock: drive, check in_ready, advance model, check outputs.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        logic slot, hz, exp_rdy;
        in_valid = v; instruction = ins; pc_in = pc; out_ready = ordy; flush = fl;
        #1;
        slot = !m.vld || ordy;
        hz   = 1'b0;
`ifdef LOAD_USE_STALL_EN
        hz = v && m_ldv && ((reads_rs(ins) && ins[25:21] == m_ldrt) ||
                            (reads_rt(ins) && ins[20:16] == m_ldrt));
`endif
        exp_rdy = slot && !hz;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        if (fl) begin
            m.vld = 1'b0; m_ldv = 1'b0;
        end else if (v && exp_rdy) begin
            m      = decode(ins, pc);
            m_ldv  = (mnem(ins) == "LW") && (ins[20:16] != 5'd0);
            m_ldrt = ins[20:16];
        end else if (slot) begin
            m.vld = 1'b0; m_ldv = 1'b0;
            if (hz && m_stall < 65535) m_stall++;
        end
        #1;
        compare();
    endtask

    logic [31:0] misc [12] = '{32'hAC450008, 32'h1043FFFE, 32'h14430004, 32'h08000123,
                               32'h8C000004, 32'h00001820, 32'h00221822, 32'h00221824,
                               32'h00221825, 32'h0022182A, 32'h03E00008, 32'h0022183F};

    initial begin
        m = '0; m_ldv = 1'b0; m_ldrt = '0; m_stall = 0;
        #1;
        compare();
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        #12 rst_n = 1'b1;

        step(1, 32'h00221820, 32'h100, 1, 0);
        chk("add_lit", 64'({out_valid, reg_dst, alu_ctrl, reg_write, rd, illegal}),
            64'({1'b1, 2'b01, 3'd0, 1'b1, 5'd3, 1'b0}));
        step(1, 32'h2005FFFF, 32'h104, 1, 0);
        chk("addi_lit", 64'({imm_ext, alu_src}), 64'({32'hFFFFFFFF, 1'b1}));
        step(1, 32'h3806FFFF, 32'h108, 1, 0);
        chk("xori_lit", 64'({imm_ext, alu_ctrl}), 64'({32'h0000FFFF, 3'd2}));
        step(1, 32'h0C000010, 32'h10C, 1, 0);
        chk("jal_lit", 64'({jump, reg_dst, mem_to_reg, imm_ext, target}),
            64'({2'b10, 2'b10, 2'b10, 32'd8, 26'h10}));
        step(1, 32'hFC000000, 32'h110, 1, 0);
        chk("ill_lit", 64'({illegal, reg_write}), 64'({1'b1, 1'b0}));

        for (int k = 0; k < 12; k++) step(1, misc[k], 32'h200 + 32'(4 * k), 1, 0);

        // Back-pressure with a flush in the middle.
        step(1, 32'h00221820, 32'h300, 1, 0);
        step(1, 32'h2005FFFF, 32'h304, 0, 0);
        chk("hold_lit", 64'({out_valid, rd, pc_out}), 64'({1'b1, 5'd3, 32'h300}));
        step(1, 32'h2005FFFF, 32'h304, 0, 1);
        chk("flush_lit", 64'(out_valid), 64'd0);
        step(1, 32'h2005FFFF, 32'h304, 0, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        // Load-use pair.
        step(1, 32'h8C220004, 32'h400, 1, 0);
        step(1, 32'h00421820, 32'h404, 1, 0);
`ifdef LOAD_USE_STALL_EN
        chk("lu_bubble", 64'(out_valid), 64'd0);
        step(1, 32'h00421820, 32'h404, 1, 0);
        chk("lu_after", 64'({out_valid, rd, stall_cnt}), 64'({1'b1, 5'd3, 16'd1}));
`else
        chk("lu_nobubble", 64'({out_valid, rd, pc_out}), 64'({1'b1, 5'd3, 32'h404}));
`endif
        step(0, 32'h0, 32'h0, 1, 0);

        // Reset in the middle of a held bundle.
        step(1, 32'h00221820, 32'h500, 0, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        m = '0; m_ldv = 1'b0; m_stall = 0;
        chk("async_rst", 64'(out_valid), 64'd0);
        compare();
        rst_n = 1'b1;
        step(0, 32'h0, 32'h0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
